// File: rtl/coprocessor_pkg.sv
// Shared definitions for the frame writer: geometry encodings, frame
// dimensions and the writer FSM state type.
package coprocessor_pkg;

    typedef enum logic [1:0] {
        IMG_160X120 = 2'd0,
        IMG_320X240 = 2'd1,
        IMG_80X60   = 2'd2,
        IMG_RSVD    = 2'd3
    } image_state_e;

    localparam int W_160X120 = 160;
    localparam int H_160X120 = 120;
    localparam int W_320X240 = 320;
    localparam int H_320X240 = 240;
    localparam int W_80X60   = 80;
    localparam int H_80X60   = 60;

    // Pixel counts are elaboration-time constants; no runtime multiply.
    localparam int N_160X120 = W_160X120 * H_160X120;
    localparam int N_320X240 = W_320X240 * H_320X240;
    localparam int N_80X60   = W_80X60 * H_80X60;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } fw_state_e;

endpackage

// File: rtl/frame_geometry.sv
// Geometry lookup: maps the latched IMAGE_STATE code to the index of the
// last pixel in the frame (N-1). The reserved code behaves as 160x120.
module frame_geometry
    import coprocessor_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic [1:0]        image_state,
    output logic [ADDR_W-1:0] last_idx
);

    // Constant table lookup of the final pixel index
    always_comb begin
        case (image_state_e'(image_state))
            IMG_320X240: last_idx = ADDR_W'(N_320X240 - 1);
            IMG_80X60:   last_idx = ADDR_W'(N_80X60 - 1);
            default:     last_idx = ADDR_W'(N_160X120 - 1);
        endcase
    end

endmodule

// File: rtl/frame_writer.sv
// Frame writer: accepts a raster-order pixel stream and writes it to a
// frame buffer at incrementing addresses, one write per accepted pixel,
// pulsing DONE once the whole frame has been written.
// Optional clear pass (fill with CLEAR_VALUE before the stream) is built
// only when FRAME_WRITER_CLEAR_EN is defined.
module frame_writer
    import coprocessor_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int CLEAR_VALUE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        IMAGE_STATE,
    input  logic [DATA_W-1:0] PIXEL_IN,
    input  logic              PIXEL_VALID,
    output logic              PIXEL_READY,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [DATA_W-1:0] W_DATA,
    output logic              WREN,
    output logic              BUSY,
    output logic              DONE
);

    fw_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        geo_q, geo_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              wren_q, wren_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] last_idx;
    logic              cnt_last;
    logic              xfer;

    frame_geometry #(
        .ADDR_W(ADDR_W)
    ) u_geometry (
        .image_state(geo_q),
        .last_idx   (last_idx)
    );

    assign cnt_last = (cnt_q == last_idx);
    // READY is registered from the next state, so it is high exactly in WRITE
    assign xfer     = ready_q & PIXEL_VALID;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        geo_d    = geo_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    geo_d = IMAGE_STATE;
                    cnt_d = '0;
`ifdef FRAME_WRITER_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = WRITE;
`endif
                end
            end
`ifdef FRAME_WRITER_CLEAR_EN
            CLEAR: begin
                wren_d   = 1'b1;
                w_addr_d = cnt_q;
                w_data_d = DATA_W'(CLEAR_VALUE);
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            WRITE: begin
                if (xfer) begin
                    wren_d   = 1'b1;
                    w_addr_d = cnt_q;
                    w_data_d = PIXEL_IN;
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                // First FINISH cycle lets the last write land; second shows DONE
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers, all cleared asynchronously by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            geo_q    <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            wren_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            geo_q    <= geo_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            wren_q   <= wren_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign PIXEL_READY = ready_q;
    assign W_ADDR      = w_addr_q;
    assign W_DATA      = w_data_q;
    assign WREN        = wren_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: geometry lookup table, full frames
// with and without stream gaps, START while busy, START on the DONE cycle,
// valid-while-idle, and reset mid-frame followed by a clean restart.
module tb_frame_writer;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int CLEAR_VALUE = 0;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              START;
    logic [1:0]        IMAGE_STATE;
    logic [DATA_W-1:0] PIXEL_IN;
    logic              PIXEL_VALID;
    logic              PIXEL_READY;
    logic [ADDR_W-1:0] W_ADDR;
    logic [DATA_W-1:0] W_DATA;
    logic              WREN;
    logic              BUSY;
    logic              DONE;

    logic [1:0]        g_in;
    logic [ADDR_W-1:0] g_last;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    frame_writer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLEAR_VALUE(CLEAR_VALUE)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .IMAGE_STATE(IMAGE_STATE),
        .PIXEL_IN   (PIXEL_IN),
        .PIXEL_VALID(PIXEL_VALID),
        .PIXEL_READY(PIXEL_READY),
        .W_ADDR     (W_ADDR),
        .W_DATA     (W_DATA),
        .WREN       (WREN),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    frame_geometry #(
        .ADDR_W(ADDR_W)
    ) geo_ref (
        .image_state(g_in),
        .last_idx   (g_last)
    );

    typedef struct {
        logic [1:0]        img;
        logic [ADDR_W-1:0] last;
    } geo_vec_t;

    typedef struct {
        logic [1:0] img;
        bit         gaps;
        int         start_at;
        logic [1:0] alt_img;
        int         n;
        int         abort_at;
        bit         start_on_done;
        int         doff;
    } frame_vec_t;

    geo_vec_t   gv[4];
    frame_vec_t fv[5];

`ifdef FRAME_WRITER_CLEAR_EN
    localparam int CLEAR_TAIL = 1;
`else
    localparam int CLEAR_TAIL = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_frame(input int r, input frame_vec_t v);
        int                idx;
        int                mism;
        int                wr_seen;
        int                cyc;
        bit                started;
        bit                bad;
        logic              exp_wren;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;

        chk($sformatf("r%0d_idle_busy", r), BUSY, 1'b0);
        START       = 1'b1;
        IMAGE_STATE = v.img;
        PIXEL_VALID = 1'b0;
        step();
        START = 1'b0;
        chk($sformatf("r%0d_busy_after_start", r), BUSY, 1'b1);

        exp_wren = 1'b0;
        exp_addr = '0;
        exp_data = '0;
`ifdef FRAME_WRITER_CLEAR_EN
        mism = 0;
        for (int k = 0; k < v.n; k++) begin
            PIXEL_VALID = 1'b1;
            PIXEL_IN    = 8'hFF;
            if (PIXEL_READY !== 1'b0 || WREN !== exp_wren ||
                (exp_wren && (W_ADDR !== exp_addr || W_DATA !== exp_data)))
                mism++;
            exp_wren = 1'b1;
            exp_addr = ADDR_W'(k);
            exp_data = DATA_W'(CLEAR_VALUE);
            step();
        end
        chk($sformatf("r%0d_clear_bad_cycles", r), mism, 0);
`endif

        idx     = 0;
        mism    = 0;
        wr_seen = 0;
        cyc     = 0;
        started = 1'b0;
        while (idx < v.n && cyc < v.n * 3 + 100) begin
            if (v.abort_at >= 0 && idx == v.abort_at) break;
            bad = (PIXEL_READY !== 1'b1) || (BUSY !== 1'b1) || (DONE !== 1'b0) ||
                  (WREN !== exp_wren) ||
                  (exp_wren && (W_ADDR !== exp_addr || W_DATA !== exp_data));
            if (bad) begin
                if (mism == 0)
                    $display("  r%0d first bad cycle idx=%0d: rdy=%b wren=%b addr=%0d data=%0h want wren=%b addr=%0d data=%0h",
                             r, idx, PIXEL_READY, WREN, W_ADDR, W_DATA, exp_wren, exp_addr, exp_data);
                mism++;
            end
            if (WREN === 1'b1) wr_seen++;

            START = 1'b0;
            if (v.start_at >= 0 && idx == v.start_at && !started) begin
                START   = 1'b1;
                started = 1'b1;
            end
            IMAGE_STATE = started ? v.alt_img : v.img;
            PIXEL_VALID = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            PIXEL_IN    = DATA_W'(idx + v.doff);
            exp_wren    = PIXEL_VALID;
            if (PIXEL_VALID) begin
                exp_addr = ADDR_W'(idx);
                exp_data = PIXEL_IN;
                idx++;
            end
            step();
            cyc++;
        end
        START = 1'b0;
        chk($sformatf("r%0d_stream_bad_cycles", r), mism, 0);

        if (v.abort_at >= 0) begin
            // Reset lands between clock edges while a write is outstanding
            PIXEL_VALID = 1'b1;
            #1 RESET = 1'b0;
            #1;
            chk($sformatf("r%0d_reset_outputs", r),
                {W_ADDR, W_DATA, WREN, BUSY, DONE, PIXEL_READY}, '0);
            mism = 0;
            START = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step();
                if (WREN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) mism++;
            end
            chk($sformatf("r%0d_quiet_in_reset", r), mism, 0);
            RESET       = 1'b1;
            START       = 1'b0;
            PIXEL_VALID = 1'b0;
            step();
            chk($sformatf("r%0d_idle_after_reset", r), {BUSY, DONE, WREN}, 3'b000);
            return;
        end

        chk($sformatf("r%0d_transfers", r), idx, v.n);

        // Last write lands, FSM in FINISH; stream input must be ignored
        PIXEL_VALID = 1'b1;
        PIXEL_IN    = 8'hEE;
        if (WREN === 1'b1) wr_seen++;
        chk($sformatf("r%0d_last_write", r), {WREN, W_ADDR, W_DATA, DONE, BUSY, PIXEL_READY},
            {1'b1, ADDR_W'(v.n - 1), exp_data, 1'b0, 1'b1, 1'b0});
        step();
        chk($sformatf("r%0d_done_pulse", r), {DONE, WREN, BUSY}, 3'b101);
        if (v.start_on_done) begin
            START       = 1'b1;
            IMAGE_STATE = v.img;
        end
        step();
        START = 1'b0;
        chk($sformatf("r%0d_back_idle", r), {DONE, WREN, BUSY}, 3'b000);
        step();
        chk($sformatf("r%0d_still_idle", r), {DONE, WREN, BUSY, PIXEL_READY}, 4'b0000);
        PIXEL_VALID = 1'b0;
        chk($sformatf("r%0d_write_count", r), wr_seen, v.n + CLEAR_TAIL);
    endtask

    initial begin
        int mism;

        gv[0] = '{2'd0, 17'd19199};
        gv[1] = '{2'd1, 17'd76799};
        gv[2] = '{2'd2, 17'd4799};
        gv[3] = '{2'd3, 17'd19199};

        //        img   gaps start alt   n      abort done_st doff
        fv[0] = '{2'd0, 1'b0, -1,  2'd0, 19200, -1,   1'b1,   0};
        fv[1] = '{2'd2, 1'b1, -1,  2'd0, 4800,  -1,   1'b0,   17};
        fv[2] = '{2'd2, 1'b0, 100, 2'd1, 4800,  -1,   1'b0,   99};
        fv[3] = '{2'd2, 1'b1, -1,  2'd0, 4800,  500,  1'b0,   5};
        fv[4] = '{2'd2, 1'b0, -1,  2'd0, 4800,  -1,   1'b0,   200};

        RESET       = 1'b0;
        START       = 1'b0;
        IMAGE_STATE = 2'd0;
        PIXEL_IN    = '0;
        PIXEL_VALID = 1'b0;
        g_in        = 2'd0;

        for (int i = 0; i < 4; i++) begin
            g_in = gv[i].img;
            #1;
            chk($sformatf("geo_last_%0d", i), g_last, gv[i].last);
        end

        step();
        step();
        chk("reset_state", {W_ADDR, W_DATA, WREN, BUSY, DONE, PIXEL_READY}, '0);
        RESET = 1'b1;
        step();

        // Valid pixels offered while idle must not write
        mism = 0;
        PIXEL_VALID = 1'b1;
        PIXEL_IN    = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            step();
            if (WREN !== 1'b0 || PIXEL_READY !== 1'b0 || BUSY !== 1'b0) mism++;
        end
        PIXEL_VALID = 1'b0;
        chk("idle_valid_ignored", mism, 0);

        for (int r = 0; r < 5; r++) begin
            run_frame(r, fv[r]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, meaning write-address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning pixel width.
REQ-003 The block SHALL have parameter CLEAR_VALUE, default 0, meaning the fill pixel used by the clear pass.
REQ-004 CLK  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 START  input  1  frame-write request, sampled in IDLE only.
REQ-007 IMAGE_STATE  input  2  frame geometry: 0=160x120, 1=320x240, 2=80x60, 3=reserved (treated as 0).
REQ-008 PIXEL_IN  input  DATA_W  stream pixel, raster order.
REQ-009 PIXEL_VALID  input  1  PIXEL_IN is valid.
REQ-010 PIXEL_READY  output  1  block accepts a pixel this cycle.
REQ-011 W_ADDR  output  ADDR_W  frame-buffer write address.
REQ-012 W_DATA  output  DATA_W  frame-buffer write data.
REQ-013 WREN  output  1  frame-buffer write strobe.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, WRITE and FINISH.
REQ-017 In IDLE with START=1, the block SHALL latch IMAGE_STATE and compute N = width*height (19200, 76800 or 4800).
REQ-018 From IDLE on START, the FSM SHALL enter CLEAR when the clear feature is compiled in, else WRITE.
REQ-019 A pixel SHALL transfer only on a cycle with PIXEL_VALID=1 and PIXEL_READY=1; PIXEL_READY SHALL be 1 only in WRITE.
REQ-020 Each transfer SHALL produce, one cycle later, WREN=1 with W_DATA=PIXEL_IN and W_ADDR equal to the transfer's index (0..N-1).
REQ-021 WREN SHALL be 0 on cycles with no transfer or clear write.
REQ-022 The address SHALL come from an incrementing counter with no multiplier, and SHALL never exceed N-1.
REQ-023 After the transfer at index N-1, the FSM SHALL enter FINISH, where DONE=1 for exactly one cycle, then return to IDLE.
REQ-024 START asserted while BUSY=1 SHALL be ignored, and the latched geometry SHALL stay unchanged.
REQ-025 PIXEL_VALID while not in WRITE SHALL be ignored, with no write and no counter change.
REQ-026 A stalled stream (PIXEL_VALID=0) SHALL hold the counter and state indefinitely.
REQ-027 START and completion arriving in the same cycle SHALL NOT start a new frame; START is honoured only from IDLE on a later cycle.

Reset
REQ-028 On RESET=0, the block SHALL immediately set the FSM to IDLE and clear the counter, W_ADDR, W_DATA, WREN, PIXEL_READY, BUSY and DONE to 0.
REQ-029 A reset mid-frame SHALL abandon the frame with no DONE pulse, and no write SHALL occur after reset assertion.

Configuration
REQ-030 The clear pass SHALL be controlled by macro FRAME_WRITER_CLEAR_EN.
REQ-031 With FRAME_WRITER_CLEAR_EN defined, CLEAR SHALL write CLEAR_VALUE to addresses 0..N-1 at one per cycle, with PIXEL_READY=0, then enter WRITE with the counter at 0.
REQ-032 Without FRAME_WRITER_CLEAR_EN, the CLEAR state and its logic SHALL be absent, and START SHALL lead directly to WRITE.

Structure
REQ-033 Shared package coprocessor_pkg SHALL hold the IMAGE_STATE encodings, the width/height constants per geometry, and the FSM state typedef.
REQ-034 The geometry lookup (IMAGE_STATE to N) SHALL be a sub-module named frame_geometry; everything else SHALL stay in frame_writer.

Verification
REQ-035 Scenario: reset, then START with IMAGE_STATE=0 and 19200 back-to-back valid pixels of value index mod 256 -> 19200 writes at addresses 0..19199 with matching data, then DONE high for one cycle exactly 2 cycles after the last transfer, then IDLE.
REQ-036 Scenario: IMAGE_STATE=1 with random VALID gaps -> exactly 76800 writes, last W_ADDR=76799, and no WREN in gap cycles.
REQ-037 Scenario: START pulsed at pixel 100 of an IMAGE_STATE=2 frame with IMAGE_STATE changed to 1 -> the frame still completes after 4800 writes.
REQ-038 Scenario: RESET asserted at pixel 500 -> all outputs 0 the same cycle, no DONE, and the next START restarts at address 0.
REQ-039 Scenario: with FRAME_WRITER_CLEAR_EN and IMAGE_STATE=2 -> 4800 writes of 0 with PIXEL_READY=0, then the stream writes begin at address 0; without the macro, the first write is the first pixel.
